// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: converts a spike train into a decaying synaptic current
// and, optionally, a windowed spike-rate count.
//
// Parameters
//   WIN_LOG2    rate window is 2**WIN_LOG2 enabled cycles (1..8)
//   DECAY_SHIFT current decays by current>>DECAY_SHIFT per enabled cycle (1..7)
// Ports
//   clk        clock, all state updates on its rising edge
//   rst_n      synchronous active-low reset
//   en         enable; low freezes all state and ignores spike_in
//   spike_in   one spike per high cycle
//   weight     unsigned weight added to the current per spike
//   current    registered synaptic current (saturates at 255)
//   rate       registered spike count of the last completed window
//   rate_valid one-cycle pulse on each rate update
// Configuration
//   SPIKE_RATE_DECODER_RATE_EN  when defined, builds the window/spike counters;
//                               otherwise rate and rate_valid are tied to 0.

module spike_rate_decoder #(
   parameter int unsigned WIN_LOG2    = 4,
   parameter int unsigned DECAY_SHIFT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       spike_in,
   input  logic [7:0] weight,
   output logic [7:0] current,
   output logic [7:0] rate,
   output logic       rate_valid
);

   localparam int unsigned DW = 8;
   localparam int unsigned SW = DW + 1;

   // Elaboration-time parameter range guard
   if (WIN_LOG2 < 1 || WIN_LOG2 > 8) begin : g_bad_win_log2
      $error("WIN_LOG2 must be in 1..8");
   end
   if (DECAY_SHIFT < 1 || DECAY_SHIFT > 7) begin : g_bad_decay_shift
      $error("DECAY_SHIFT must be in 1..7");
   end

   logic [DW-1:0] cur_q, cur_d;
   logic [DW-1:0] decay_c;
   logic [SW-1:0] sum_c;

   // Current update: decay (floored at 1 while nonzero) plus weighted spike
   always_comb begin
      decay_c = cur_q >> DECAY_SHIFT;
      sum_c   = '0;
      cur_d   = cur_q;
      if (cur_q != '0 && decay_c == '0) begin
         decay_c = DW'(1);
      end
      // Worst case 255 - 1 + 255 fits in 9 bits; decay never exceeds cur_q
      sum_c = SW'(cur_q) - SW'(decay_c) + (spike_in ? SW'(weight) : SW'(0));
      if (en) begin
         cur_d = sum_c[SW-1] ? '1 : sum_c[DW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_q <= '0;
      end else begin
         cur_q <= cur_d;
      end
   end

   assign current = cur_q;

`ifdef SPIKE_RATE_DECODER_RATE_EN
   localparam int unsigned WW = WIN_LOG2;
   localparam logic [WW-1:0] WIN_MAX = '1;

   logic [WW-1:0] win_q, win_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] rate_q, rate_d;
   logic          valid_q, valid_d;
   logic [DW-1:0] cnt_inc_c;

   // Window/spike counters; the closing cycle's spike is folded into rate
   always_comb begin
      win_d     = win_q;
      cnt_d     = cnt_q;
      rate_d    = rate_q;
      valid_d   = 1'b0;
      cnt_inc_c = (spike_in && cnt_q != '1) ? cnt_q + DW'(1) : cnt_q;
      if (en) begin
         win_d = win_q + WW'(1);
         if (win_q == WIN_MAX) begin
            rate_d  = cnt_inc_c;
            cnt_d   = '0;
            valid_d = 1'b1;
         end else begin
            cnt_d = cnt_inc_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win_q   <= '0;
         cnt_q   <= '0;
         rate_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         rate_q  <= rate_d;
         valid_q <= valid_d;
      end
   end

   assign rate       = rate_q;
   assign rate_valid = valid_q;
`else
   assign rate       = '0;
   assign rate_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder (WIN_LOG2=4, DECAY_SHIFT=2).
// Current-path vectors come from a table; rate-window corner cases are
// hand-written sequences. Expected values are queued when stimulus is driven
// and popped for comparison one cycle later.

module tb_spike_rate_decoder;

`ifdef SPIKE_RATE_DECODER_RATE_EN
   localparam bit RATE_EN = 1'b1;
`else
   localparam bit RATE_EN = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       spike_in;
   logic [7:0] weight;
   logic [7:0] current;
   logic [7:0] rate;
   logic       rate_valid;

   spike_rate_decoder #(
      .WIN_LOG2   (4),
      .DECAY_SHIFT(2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .spike_in  (spike_in),
      .weight    (weight),
      .current   (current),
      .rate      (rate),
      .rate_valid(rate_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       rst_n;
      logic       spike;
      logic [7:0] weight;
      logic [7:0] cur;
      logic [7:0] rate;
      logic       valid;
      string      name;
   } vec_t;

   typedef struct {
      logic [7:0] cur;
      logic [7:0] rate;
      logic       valid;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic cmp8(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
   endtask

   // Drive one cycle, queue its expectation, then compare after the edge
   task automatic step(input logic e, input logic r, input logic s, input logic [7:0] w,
                       input logic [7:0] ec, input logic [7:0] er, input logic ev,
                       input string name);
      exp_t x;
      en       = e;
      rst_n    = r;
      spike_in = s;
      weight   = w;
      x.cur    = ec;
      x.rate   = RATE_EN ? er : 8'd0;
      x.valid  = RATE_EN ? ev : 1'b0;
      x.name   = name;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         x = exp_q.pop_front();
         cmp8({x.name, "/current"}, current, x.cur);
         cmp8({x.name, "/rate"}, rate, x.rate);
         cmp8({x.name, "/rate_valid"}, 8'(rate_valid), 8'(x.valid));
      end
   endtask

   vec_t vecs[21];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      en = 1'b0; rst_n = 1'b0; spike_in = 1'b0; weight = 8'd0;

      vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd0,   8'd0,   8'd0, 1'b0, "reset"};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 8'd100, 8'd100, 8'd0, 1'b0, "decay_load"};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'd100, 8'd75,  8'd0, 1'b0, "decay1"};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'd100, 8'd57,  8'd0, 1'b0, "decay2"};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'd100, 8'd43,  8'd0, 1'b0, "decay3"};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'd100, 8'd33,  8'd0, 1'b0, "decay4"};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'd0,   8'd0,   8'd0, 1'b0, "reset2"};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'd3,   8'd3,   8'd0, 1'b0, "floor_load"};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'd3,   8'd2,   8'd0, 1'b0, "floor1"};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'd3,   8'd1,   8'd0, 1'b0, "floor2"};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 8'd3,   8'd0,   8'd0, 1'b0, "floor3"};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 8'd3,   8'd0,   8'd0, 1'b0, "floor_stay"};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 8'd0,   8'd0,   8'd0, 1'b0, "reset3"};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 8'd200, 8'd200, 8'd0, 1'b0, "sat_first"};
      vecs[14] = '{1'b1, 1'b1, 1'b1, 8'd200, 8'd255, 8'd0, 1'b0, "sat_clip"};
      vecs[15] = '{1'b1, 1'b1, 1'b1, 8'd0,   8'd192, 8'd0, 1'b0, "w0_decay1"};
      vecs[16] = '{1'b1, 1'b1, 1'b1, 8'd0,   8'd144, 8'd0, 1'b0, "w0_decay2"};
      vecs[17] = '{1'b0, 1'b1, 1'b1, 8'd200, 8'd144, 8'd0, 1'b0, "en_low_hold"};
      vecs[18] = '{1'b1, 1'b1, 1'b0, 8'd200, 8'd108, 8'd0, 1'b0, "resume_decay"};
      vecs[19] = '{1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 8'd0, 1'b0, "sat_clip2"};
      vecs[20] = '{1'b0, 1'b0, 1'b1, 8'd255, 8'd0,   8'd0, 1'b0, "reset_en_low"};

      foreach (vecs[i])
         step(vecs[i].en, vecs[i].rst_n, vecs[i].spike, vecs[i].weight,
              vecs[i].cur, vecs[i].rate, vecs[i].valid, vecs[i].name);

      // Alternate-cycle spikes over a full window after reset -> rate 8
      for (int i = 0; i < 16; i++)
         step(1'b1, 1'b1, (i % 2) == 0, 8'd0, 8'd0,
              (i == 15) ? 8'd8 : 8'd0, i == 15, "rate_alt");

      // Only spike on the closing cycle -> rate 1
      for (int i = 0; i < 16; i++)
         step(1'b1, 1'b1, i == 15, 8'd0, 8'd0,
              (i == 15) ? 8'd1 : 8'd8, i == 15, "last_cycle");

      // Enable low mid-window with spikes present: frozen, window resumes
      for (int i = 0; i < 8; i++)
         step(1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 8'd1, 1'b0, "pre_freeze");
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 8'd1, 1'b0, "en_freeze");
      for (int i = 0; i < 8; i++)
         step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0,
              (i == 7) ? 8'd8 : 8'd1, i == 7, "resume_win");

      // Reset mid-window discards the partial count; next window is full length
      for (int i = 0; i < 5; i++)
         step(1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 8'd8, 1'b0, "pre_reset");
      step(1'b1, 1'b0, 1'b1, 8'd50, 8'd0, 8'd0, 1'b0, "mid_reset");
      for (int i = 0; i < 16; i++)
         step(1'b1, 1'b1, 1'b1, 8'd0, 8'd0,
              (i == 15) ? 8'd16 : 8'd0, i == 15, "post_reset_win");
      step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd16, 1'b0, "rate_hold");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 4, meaning the rate window is 2^WIN_LOG2 cycles (legal 1..8).
REQ-002 SHALL have parameter DECAY_SHIFT, default 2, meaning the synaptic current decays by current>>DECAY_SHIFT per enabled cycle (legal 1..7).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning the reset, which is synchronous and active-low.
REQ-005 SHALL have port en  input  1  meaning the enable; low freezes all state.
REQ-006 SHALL have port spike_in  input  1  meaning the incoming spike, one spike per high cycle.
REQ-007 SHALL have port weight  input  8  meaning the unsigned synaptic weight added per spike.
REQ-008 SHALL have port current  output  8  meaning the registered synaptic current, suitable to drive a LIF current input.
REQ-009 SHALL have port rate  output  8  meaning the registered spike count of the last completed window.
REQ-010 SHALL have port rate_valid  output  1  meaning a one-cycle pulse marking a rate update.

Function
REQ-011 SHALL, on an edge with en=1, compute d = current>>DECAY_SHIFT, or d = 1 when current is nonzero and the shift yields 0, so that current always decays to 0.
REQ-012 SHALL, on that edge, compute current_next = current - d + (spike_in ? weight : 0) at 9-bit width and saturate it at 255.
REQ-013 SHALL register current with a latency of one cycle, so a spike sampled on edge N is visible after edge N.
REQ-014 SHALL keep an internal window counter that steps 0..2^WIN_LOG2-1 on each enabled edge and wraps to 0.
REQ-015 SHALL keep an internal spike counter that increments on each enabled edge with spike_in=1 and saturates at 255.
REQ-016 SHALL, on the enabled edge where the window counter equals its maximum, load rate with the saturated sum of the spike counter and spike_in, so a last-cycle spike counts in the closing window.
REQ-017 SHALL, on that same edge, clear the spike counter to 0 and set rate_valid to 1 for exactly one cycle.
REQ-018 SHALL drive rate_valid to 0 on every other edge.
REQ-019 SHALL hold rate between updates.
REQ-020 SHALL, on an edge with en=0, hold current, rate and both counters, drive rate_valid to 0, and ignore spike_in.
REQ-021 SHALL, when en rises again, resume the window from the held count without restarting it.

Reset
REQ-022 SHALL, on an edge with rst_n=0, clear current, rate, rate_valid, the window counter and the spike counter to 0, regardless of en or spike_in.
REQ-023 SHALL, on reset mid-window, discard the partial count, and the first window after reset SHALL be a full 2^WIN_LOG2 enabled cycles.

Configuration
REQ-024 SHALL, when macro SPIKE_RATE_DECODER_RATE_EN is defined, implement the window counter, spike counter, rate and rate_valid as specified above.
REQ-025 SHALL, when SPIKE_RATE_DECODER_RATE_EN is undefined, omit the window and spike counter logic, tie rate to 0 and rate_valid to 0, and leave the current path unchanged.

Verification
REQ-026 SHALL cover decay: weight=100, one spike after reset, then idle -> current 100, 75, 57, 43, 33 on successive edges.
REQ-027 SHALL cover the residue floor: current=3 with no spikes -> current 2, 1, 0, then stays at 0.
REQ-028 SHALL cover saturation: weight=200 with spikes on two consecutive edges -> current 200, then 255; weight=0 with spikes -> current changes by decay only.
REQ-029 SHALL cover the rate window (macro defined, WIN_LOG2=4): spikes on alternate cycles over 16 enabled cycles -> rate=8 and rate_valid high for one cycle at edge 16.
REQ-030 SHALL cover the last-cycle spike: a window whose only spike is on its 16th cycle -> rate=1.
REQ-031 SHALL cover enable and reset: en=0 for 5 cycles mid-window with spikes present -> outputs frozen and rate_valid low; rst_n=0 mid-window -> all outputs 0 on the next edge, and the next rate_valid arrives 16 enabled cycles after reset release.
